// File: rtl/vlsu_agen_if.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_agen_if
// Description : Request/beat bundle between a vector-memory sequencer and the
//               vlsu_agen address generator. The master side issues vector
//               memory operations; the slave side (the generator) returns
//               per-lane byte addresses and access codes, one beat at a time.
// Revision    : 1.0 - initial release
// ============================================================================
interface vlsu_agen_if #(
    parameter int XLEN   = 32,
    parameter int VL_MAX = 32
);
    // Operation request
    logic              start;
    logic              flush;
    logic              isStore;
    logic [1:0]        eew;
    logic [XLEN-1:0]   base;
    logic [XLEN-1:0]   stride;
    logic [5:0]        vl;
    logic              vm;
    logic [VL_MAX-1:0] vmask;
    logic              memReady;

    // Status and beat outputs
    logic              busy;
    logic              beatValid;
    logic              done;
    logic [5:0]        elemBase;
    logic [XLEN-1:0]   VALU0;
    logic [XLEN-1:0]   VALU1;
    logic [XLEN-1:0]   VALU2;
    logic [XLEN-1:0]   VALU3;
    logic              vm0;
    logic              vm1;
    logic              vm2;
    logic              vm3;
    logic [2:0]        VWe0;
    logic [2:0]        VWe1;
    logic [2:0]        VWe2;
    logic [2:0]        VWe3;
    logic [2:0]        REn0;
    logic [2:0]        REn1;
    logic [2:0]        REn2;
    logic [2:0]        REn3;

    // Requester side
    modport master (
        output start, flush, isStore, eew, base, stride, vl, vm, vmask, memReady,
        input  busy, beatValid, done, elemBase,
        input  VALU0, VALU1, VALU2, VALU3,
        input  vm0, vm1, vm2, vm3,
        input  VWe0, VWe1, VWe2, VWe3,
        input  REn0, REn1, REn2, REn3
    );

    // Address-generator side
    modport slave (
        input  start, flush, isStore, eew, base, stride, vl, vm, vmask, memReady,
        output busy, beatValid, done, elemBase,
        output VALU0, VALU1, VALU2, VALU3,
        output vm0, vm1, vm2, vm3,
        output VWe0, VWe1, VWe2, VWe3,
        output REn0, REn1, REn2, REn3
    );
endinterface
`default_nettype wire

// File: rtl/vlsu_agen.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_agen
// Description : Vector load/store address generator. Expands one strided,
//               optionally masked vector memory operation into beats of four
//               lanes, each lane carrying a byte address, an active flag and a
//               read or write access code. Addresses advance incrementally by
//               4*stride per accepted beat, so no multiplier is needed.
// Revision    : 1.0 - initial release
// ============================================================================
module vlsu_agen #(
    parameter int XLEN   = 32,
    parameter int LANES  = 4,
    parameter int VL_MAX = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    vlsu_agen_if.slave  bus
);

    localparam logic [5:0] c_VL_MAX = 6'(VL_MAX);
    localparam logic [5:0] c_LANES  = 6'(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    // Operands captured at start; frozen for the life of the operation
    logic                r_isStore;
    logic [1:0]          r_eew;
    logic [XLEN-1:0]     r_step;        // 4*stride, the per-beat address advance
    logic                r_vm;
    logic [VL_MAX-1:0]   r_mask;        // shifted so bit i always belongs to lane i
    logic [5:0]          r_remain;      // elements left, counting the current beat
    logic [5:0]          r_elemBase;
    logic [XLEN-1:0]     r_addr [LANES];

    logic                w_run;
    logic                w_launch;
    logic                w_accept;
    logic                w_lastBeat;
    logic [5:0]          w_vlClamped;
    logic [2:0]          w_code;
    logic [XLEN-1:0]     w_startAddr [LANES];
    logic [XLEN-1:0]     w_laneAddr  [LANES];
    logic [LANES-1:0]    w_laneOn;
    logic [2:0]          w_laneWe    [LANES];
    logic [2:0]          w_laneRe    [LANES];

    assign w_run       = (r_state == RUN);
    assign w_launch    = (r_state == IDLE) && bus.start && !bus.flush;
    assign w_accept    = w_run && bus.memReady && !bus.flush;
    assign w_lastBeat  = (r_remain <= c_LANES);
    assign w_vlClamped = (bus.vl > c_VL_MAX) ? c_VL_MAX : bus.vl;

    // Element width to access code; the illegal width gives no access at all
    always_comb begin
        w_code = 3'b000;
        case (r_eew)
            2'b00:   w_code = 3'b001;
            2'b01:   w_code = 3'b010;
            2'b10:   w_code = 3'b011;
            default: w_code = 3'b000;
        endcase
    end

    // Start addresses of beat 0 built as a chain of adders: lane i = base + i*stride
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_startAddr
            if (i == 0) begin : g_first
                assign w_startAddr[i] = bus.base;
            end else begin : g_next
                assign w_startAddr[i] = w_startAddr[i-1] + bus.stride;
            end
        end
    endgenerate

    // Per-lane activity and access codes; everything is zero outside RUN
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_laneOn[i]   = w_run && (r_remain > 6'(i)) && (r_vm || r_mask[i]);
            assign w_laneAddr[i] = w_run ? r_addr[i] : '0;
            assign w_laneWe[i]   = (w_laneOn[i] &&  r_isStore) ? w_code : 3'b000;
            assign w_laneRe[i]   = (w_laneOn[i] && !r_isStore) ? w_code : 3'b000;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; flush wins over start and memReady
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = (w_vlClamped != 6'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.memReady && w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (bus.flush) begin
            w_nextState = IDLE;
        end
    end

    // Operand capture on launch, lane advance on each accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_isStore  <= 1'b0;
            r_eew      <= 2'b00;
            r_step     <= '0;
            r_vm       <= 1'b0;
            r_mask     <= '0;
            r_remain   <= 6'd0;
            r_elemBase <= 6'd0;
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= '0;
            end
        end else if (w_launch) begin
            r_isStore  <= bus.isStore;
            r_eew      <= bus.eew;
            r_step     <= bus.stride << 2;
            r_vm       <= bus.vm;
            r_mask     <= bus.vmask;
            r_remain   <= w_vlClamped;
            r_elemBase <= 6'd0;
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= w_startAddr[i];
            end
        end else if (w_accept) begin
            r_mask     <= r_mask >> LANES;
            r_remain   <= w_lastBeat ? 6'd0 : (r_remain - c_LANES);
            r_elemBase <= r_elemBase + c_LANES;
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= r_addr[i] + r_step;
            end
        end
    end

    // Status outputs decoded straight from the state register
    assign bus.busy      = (r_state != IDLE);
    assign bus.beatValid = w_run;
    assign bus.done      = (r_state == DONE);
    assign bus.elemBase  = w_run ? r_elemBase : 6'd0;

    assign bus.VALU0 = w_laneAddr[0];
    assign bus.VALU1 = w_laneAddr[1];
    assign bus.VALU2 = w_laneAddr[2];
    assign bus.VALU3 = w_laneAddr[3];

    assign bus.vm0 = w_laneOn[0];
    assign bus.vm1 = w_laneOn[1];
    assign bus.vm2 = w_laneOn[2];
    assign bus.vm3 = w_laneOn[3];

    assign bus.VWe0 = w_laneWe[0];
    assign bus.VWe1 = w_laneWe[1];
    assign bus.VWe2 = w_laneWe[2];
    assign bus.VWe3 = w_laneWe[3];

    assign bus.REn0 = w_laneRe[0];
    assign bus.REn1 = w_laneRe[1];
    assign bus.REn2 = w_laneRe[2];
    assign bus.REn3 = w_laneRe[3];

endmodule
`default_nettype wire

// File: tb/tb_vlsu_agen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vlsu_agen
// Description : Directed self-checking bench for vlsu_agen. Each task drives
//               one scenario and compares the beat outputs against
//               hand-computed values one cycle at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vlsu_agen;

    logic clk;
    logic rst_n;
    int   nPass;
    int   nTotal;

    vlsu_agen_if #(.XLEN(32), .VL_MAX(32)) bus ();

    vlsu_agen #(.XLEN(32), .LANES(4), .VL_MAX(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane views packed lane3..lane0
    function automatic logic [127:0] addrs();
        return {bus.VALU3, bus.VALU2, bus.VALU1, bus.VALU0};
    endfunction
    function automatic logic [3:0] vms();
        return {bus.vm3, bus.vm2, bus.vm1, bus.vm0};
    endfunction
    function automatic logic [11:0] wes();
        return {bus.VWe3, bus.VWe2, bus.VWe1, bus.VWe0};
    endfunction
    function automatic logic [11:0] res();
        return {bus.REn3, bus.REn2, bus.REn1, bus.REn0};
    endfunction

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one edge; returns in the first-beat cycle
    task automatic startOp(input logic st, input logic [1:0] e, input logic [31:0] b,
                           input logic [31:0] s, input logic [5:0] v, input logic m,
                           input logic [31:0] mask);
        bus.isStore = st;
        bus.eew     = e;
        bus.base    = b;
        bus.stride  = s;
        bus.vl      = v;
        bus.vm      = m;
        bus.vmask   = mask;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        nTotal++; if ({bus.busy, bus.beatValid, bus.done} !== 3'b000) $display("FAIL reset_status got=%b exp=000", {bus.busy, bus.beatValid, bus.done}); else nPass++;
        nTotal++; if (addrs() !== 128'h0) $display("FAIL reset_addr got=%h exp=0", addrs()); else nPass++;
        nTotal++; if ({wes(), res(), vms(), bus.elemBase} !== 34'h0) $display("FAIL reset_codes got=%h exp=0", {wes(), res(), vms(), bus.elemBase}); else nPass++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_unit_stride();
        bus.memReady = 1'b1;
        startOp(1'b0, 2'b10, 32'h100, 32'd4, 6'd8, 1'b1, 32'h0);
        nTotal++; if ({bus.busy, bus.beatValid, bus.done, bus.elemBase} !== {3'b110, 6'd0}) $display("FAIL us_beat0_status got=%b", {bus.busy, bus.beatValid, bus.done, bus.elemBase}); else nPass++;
        nTotal++; if (addrs() !== {32'h10C, 32'h108, 32'h104, 32'h100}) $display("FAIL us_beat0_addr got=%h exp=%h", addrs(), {32'h10C, 32'h108, 32'h104, 32'h100}); else nPass++;
        nTotal++; if ({res(), wes()} !== {12'b011_011_011_011, 12'b0}) $display("FAIL us_beat0_codes got=%b exp=%b", {res(), wes()}, {12'b011_011_011_011, 12'b0}); else nPass++;
        step();
        nTotal++; if (addrs() !== {32'h11C, 32'h118, 32'h114, 32'h110}) $display("FAIL us_beat1_addr got=%h exp=%h", addrs(), {32'h11C, 32'h118, 32'h114, 32'h110}); else nPass++;
        nTotal++; if (bus.elemBase !== 6'd4) $display("FAIL us_beat1_elemBase got=%0d exp=4", bus.elemBase); else nPass++;
        step();
        nTotal++; if ({bus.busy, bus.beatValid, bus.done} !== 3'b101) $display("FAIL us_done got=%b exp=101", {bus.busy, bus.beatValid, bus.done}); else nPass++;
        nTotal++; if ({addrs(), res()} !== 140'h0) $display("FAIL us_done_outputs got=%h exp=0", {addrs(), res()}); else nPass++;
        // start arriving while DONE must not launch anything
        bus.start = 1'b1;
        bus.vl    = 6'd4;
        step();
        bus.start = 1'b0;
        nTotal++; if ({bus.busy, bus.beatValid, bus.done} !== 3'b000) $display("FAIL us_start_in_done got=%b exp=000", {bus.busy, bus.beatValid, bus.done}); else nPass++;
    endtask

    task automatic test_masked_store();
        bus.memReady = 1'b1;
        startOp(1'b1, 2'b01, 32'h40, 32'd2, 6'd6, 1'b0, 32'h2D);
        nTotal++; if (vms() !== 4'b1101) $display("FAIL ms_beat0_vm got=%b exp=1101", vms()); else nPass++;
        nTotal++; if (addrs() !== {32'h46, 32'h44, 32'h42, 32'h40}) $display("FAIL ms_beat0_addr got=%h", addrs()); else nPass++;
        nTotal++; if ({wes(), res()} !== {12'b010_010_000_010, 12'b0}) $display("FAIL ms_beat0_codes got=%b exp=%b", {wes(), res()}, {12'b010_010_000_010, 12'b0}); else nPass++;
        step();
        nTotal++; if (vms() !== 4'b0010) $display("FAIL ms_beat1_vm got=%b exp=0010", vms()); else nPass++;
        nTotal++; if (addrs() !== {32'h4E, 32'h4C, 32'h4A, 32'h48}) $display("FAIL ms_beat1_addr got=%h", addrs()); else nPass++;
        nTotal++; if (wes() !== 12'b000_000_010_000) $display("FAIL ms_beat1_we got=%b exp=000000010000", wes()); else nPass++;
        step();
        nTotal++; if (bus.done !== 1'b1) $display("FAIL ms_done got=%b exp=1", bus.done); else nPass++;
        step();
    endtask

    task automatic test_backpressure();
        bus.memReady = 1'b0;
        startOp(1'b0, 2'b10, 32'h200, 32'd4, 6'd8, 1'b1, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            nTotal++; if ({bus.beatValid, bus.elemBase, addrs()} !== {1'b1, 6'd0, 32'h20C, 32'h208, 32'h204, 32'h200}) $display("FAIL bp_hold_c%0d got=%h", c, {bus.beatValid, bus.elemBase, addrs()}); else nPass++;
            step();
        end
        // stalled three cycles; release now, still on beat 0
        bus.memReady = 1'b1;
        nTotal++; if ({bus.elemBase, bus.VALU0, bus.done} !== {6'd0, 32'h200, 1'b0}) $display("FAIL bp_release got=%h", {bus.elemBase, bus.VALU0, bus.done}); else nPass++;
        step();
        nTotal++; if ({bus.elemBase, bus.VALU0} !== {6'd4, 32'h210}) $display("FAIL bp_beat1 got=%h", {bus.elemBase, bus.VALU0}); else nPass++;
        step();
        nTotal++; if (bus.done !== 1'b1) $display("FAIL bp_done_c6 got=%b exp=1", bus.done); else nPass++;
        step();
    endtask

    task automatic test_vl_zero();
        bus.memReady = 1'b1;
        startOp(1'b0, 2'b10, 32'h300, 32'd4, 6'd0, 1'b1, 32'h0);
        nTotal++; if ({bus.busy, bus.beatValid, bus.done} !== 3'b101) $display("FAIL vl0_done got=%b exp=101", {bus.busy, bus.beatValid, bus.done}); else nPass++;
        step();
        nTotal++; if ({bus.busy, bus.beatValid, bus.done} !== 3'b000) $display("FAIL vl0_idle got=%b exp=000", {bus.busy, bus.beatValid, bus.done}); else nPass++;
    endtask

    task automatic test_neg_stride();
        bus.memReady = 1'b1;
        startOp(1'b0, 2'b10, 32'h4, 32'hFFFF_FFFC, 6'd4, 1'b1, 32'h0);
        nTotal++; if (addrs() !== {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4}) $display("FAIL neg_addr got=%h", addrs()); else nPass++;
        step();
        nTotal++; if (bus.done !== 1'b1) $display("FAIL neg_done got=%b exp=1", bus.done); else nPass++;
        step();
    endtask

    task automatic test_codes();
        bus.memReady = 1'b1;
        startOp(1'b0, 2'b00, 32'h500, 32'd1, 6'd3, 1'b1, 32'h0);
        nTotal++; if ({vms(), res()} !== {4'b0111, 12'b000_001_001_001}) $display("FAIL byte_load got=%b", {vms(), res()}); else nPass++;
        step();
        step();
        startOp(1'b1, 2'b11, 32'h600, 32'd4, 6'd4, 1'b1, 32'h0);
        nTotal++; if ({bus.beatValid, vms(), wes(), res()} !== {1'b1, 4'b1111, 24'h0}) $display("FAIL illegal_eew got=%b", {bus.beatValid, vms(), wes(), res()}); else nPass++;
        step();
        step();
    endtask

    task automatic test_flush();
        bus.memReady = 1'b1;
        startOp(1'b0, 2'b10, 32'h100, 32'd4, 6'd8, 1'b1, 32'h0);
        // second start while busy, with different operands, must be ignored
        bus.start = 1'b1;
        bus.base  = 32'h900;
        bus.eew   = 2'b00;
        step();
        bus.start = 1'b0;
        nTotal++; if ({bus.elemBase, addrs(), res()} !== {6'd4, 32'h11C, 32'h118, 32'h114, 32'h110, 12'b011_011_011_011}) $display("FAIL flush_ignore_start got=%h", {bus.elemBase, addrs(), res()}); else nPass++;
        // flush on the last beat with memReady=1 must beat the move to DONE
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        nTotal++; if ({bus.busy, bus.beatValid, bus.done, addrs()} !== 131'h0) $display("FAIL flush_idle got=%h", {bus.busy, bus.beatValid, bus.done, addrs()}); else nPass++;
        step();
        nTotal++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL flush_no_done got=%b exp=00", {bus.busy, bus.done}); else nPass++;
    endtask

    task automatic test_async_reset();
        bus.memReady = 1'b0;
        startOp(1'b1, 2'b10, 32'h700, 32'd4, 6'd8, 1'b1, 32'h0);
        nTotal++; if (bus.beatValid !== 1'b1) $display("FAIL ar_running got=%b exp=1", bus.beatValid); else nPass++;
        #2;
        rst_n = 1'b0;
        #1;
        nTotal++; if ({bus.busy, bus.beatValid, bus.done, addrs(), wes(), vms()} !== 147'h0) $display("FAIL ar_immediate got=%h", {bus.busy, bus.beatValid, bus.done, addrs(), wes(), vms()}); else nPass++;
        step();
        nTotal++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL ar_no_done got=%b exp=00", {bus.busy, bus.done}); else nPass++;
        rst_n = 1'b1;
        bus.memReady = 1'b1;
        startOp(1'b0, 2'b01, 32'h800, 32'd2, 6'd4, 1'b1, 32'h0);
        nTotal++; if ({bus.beatValid, bus.VALU1, bus.REn1} !== {1'b1, 32'h802, 3'b010}) $display("FAIL ar_first_start got=%h", {bus.beatValid, bus.VALU1, bus.REn1}); else nPass++;
        step();
        step();
    endtask

    task automatic test_clamp();
        int         beats;
        logic [5:0] lastBase;
        logic       sawDone;
        beats    = 0;
        lastBase = 6'd0;
        sawDone  = 1'b0;
        bus.memReady = 1'b1;
        startOp(1'b0, 2'b10, 32'h0, 32'd4, 6'd40, 1'b1, 32'h0);
        for (int c = 0; c < 20; c++) begin
            if (bus.beatValid) begin
                beats++;
                lastBase = bus.elemBase;
            end
            if (bus.done) begin
                sawDone = 1'b1;
                break;
            end
            step();
        end
        nTotal++; if (sawDone !== 1'b1) $display("FAIL clamp_timeout got=%b exp=1", sawDone); else nPass++;
        nTotal++; if (beats != 8) $display("FAIL clamp_beats got=%0d exp=8", beats); else nPass++;
        nTotal++; if (lastBase !== 6'd28) $display("FAIL clamp_last_elemBase got=%0d exp=28", lastBase); else nPass++;
        step();
    endtask

    initial begin
        nPass        = 0;
        nTotal       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.isStore  = 1'b0;
        bus.eew      = 2'b00;
        bus.base     = 32'h0;
        bus.stride   = 32'h0;
        bus.vl       = 6'd0;
        bus.vm       = 1'b1;
        bus.vmask    = 32'h0;
        bus.memReady = 1'b0;
        test_reset();
        test_unit_stride();
        test_masked_store();
        test_backpressure();
        test_vl_zero();
        test_neg_stride();
        test_codes();
        test_flush();
        test_async_reset();
        test_clamp();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
